// File: rtl/vga_mem_pkg.sv
// Shared video-memory constants and the per-cycle slot owner encoding
// for the VRAM port-A arbiter.
package vga_mem_pkg;
  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 8;
  localparam int VRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_REND   = 2'd1,
    SLOT_ENG_RD = 2'd2,
    SLOT_WB     = 2'd3
  } slot_e;
endpackage

// File: rtl/vram_write_buffer.sv
// Posted-write FIFO of {addr,data} entries. The caller never pushes when full
// or pops when empty, so the pointers are free-running modulo DEPTH.
module vram_write_buffer import vga_mem_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W+DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload needs no reset: an empty FIFO is never read.
  always_ff @(posedge gclk) begin
    if (push) store[wr_ptr] <= {push_addr, push_data};
  end

  assign {head_addr, head_data} = store[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM arbiter: renderer fetch has strict priority, engine reads
// take idle slots, engine writes are posted and drained in leftover slots.
module vram_access_arbiter import vga_mem_pkg::*; #(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int RD_LAT       = VRAM_RD_LAT,
  parameter int WB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 1023
) (
  input  logic                      clk_25mhz,
  input  logic                      reset_n,
  input  logic                      rend_req,
  input  logic [ADDR_W-1:0]         rend_addr,
  output logic [DATA_W-1:0]         rend_data,
  output logic                      rend_valid,
  input  logic                      eng_req,
  input  logic                      eng_we,
  input  logic [ADDR_W-1:0]         eng_addr,
  input  logic [DATA_W-1:0]         eng_wdata,
  output logic                      eng_ack,
  output logic [DATA_W-1:0]         eng_rdata,
  output logic                      eng_rvalid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_dout,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      eng_starved
);
  localparam int STAGES = 1 + RD_LAT;
  localparam int SC_W   = $clog2(STARVE_LIMIT + 2);

  slot_e             slot;
  logic              wb_full, wb_empty, wb_push, wb_pop;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_issue, rd_busy;
  logic [STAGES:1]   rend_vld, eng_vld;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;

  // Only one engine read may be outstanding; it is busy until its data returns.
  assign rd_busy  = |eng_vld;
  assign rd_issue = eng_req & ~eng_we & wb_empty & ~rd_busy & ~rend_req;
  assign wb_push  = eng_req & eng_we & ~wb_full;
  assign eng_ack  = wb_push | rd_issue;

  always_comb begin
    slot = SLOT_IDLE;
    if (rend_req)       slot = SLOT_REND;
    else if (rd_issue)  slot = SLOT_ENG_RD;
    else if (!wb_empty) slot = SLOT_WB;
  end

  assign wb_pop = (slot == SLOT_WB);

  vram_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WB_DEPTH)
  ) u_wb (
    .gclk      (clk_25mhz),
    .grst_n    (reset_n),
    .push      (wb_push),
    .push_addr (eng_addr),
    .push_data (eng_wdata),
    .pop       (wb_pop),
    .head_addr (wb_addr),
    .head_data (wb_data),
    .count     (wb_count),
    .full      (wb_full),
    .empty     (wb_empty)
  );

  // mem_addr holds through idle slots; mem_din only moves on a drain.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= wb_pop;
      case (slot)
        SLOT_REND:   mem_addr <= rend_addr;
        SLOT_ENG_RD: mem_addr <= eng_addr;
        SLOT_WB: begin
          mem_addr <= wb_addr;
          mem_din  <= wb_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      rend_vld <= '0;
      eng_vld  <= '0;
    end else begin
      rend_vld <= {rend_vld[STAGES-1:1], slot == SLOT_REND};
      eng_vld  <= {eng_vld[STAGES-1:1], slot == SLOT_ENG_RD};
    end
  end

  assign rend_valid = rend_vld[STAGES];
  assign rend_data  = rend_valid ? mem_dout : '0;
  assign eng_rvalid = eng_vld[STAGES];
  assign eng_rdata  = eng_rvalid ? mem_dout : '0;

  // Saturates one past the limit so the comparison stays meaningful forever.
  always_comb begin
    starve_nxt = '0;
    if (eng_req && !eng_ack)
      starve_nxt = (starve_cnt > SC_W'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt  <= '0;
      eng_starved <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if (starve_nxt > SC_W'(STARVE_LIMIT)) eng_starved <= 1'b1;
    end
  end
endmodule
